lcd_char_driver: RTL
====================

Name: lcd_char_driver

Overview:
- Consumer end of the two-line ASCII display buffers (line1/line2, 128 bits each) that the register-file command interface produces.
- Runs the HD44780-compatible power-on initialisation in 4-bit mode, then continuously rewrites both 16-character rows to the board's character LCD.
- Sits between the command interface and the LCD pins at top level. Sole owner of the LCD bus.

Parameters:
- T_POWERON, 750000, cycles to wait after reset before the first init nibble (15 ms @ 50 MHz)
- T_INIT_LONG, 205000, wait after the first 0x3 init nibble (4.1 ms)
- T_INIT_SHORT, 5000, wait after the second 0x3 init nibble (100 us)
- T_CMD, 2000, wait after each full byte and after the 3rd and 4th init nibbles (40 us)
- T_CLEAR, 82000, extra wait after the Clear Display command (1.64 ms)
- T_SU, 2, cycles data/RS stable before E rises
- T_E, 12, cycles E held high
- T_H, 1, cycles data/RS held after E falls
- T_NIB, 50, gap between the upper and lower nibble of one byte (1 us)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- line1  in  128  row 0 ASCII; bits [127:120] = column 0, bits [7:0] = column 15
- line2  in  128  row 1 ASCII, same byte order
- lcd_d  out  4  LCD data nibble (DB7..DB4)
- lcd_e  out  1  LCD enable strobe
- lcd_rs  out  1  0 = command, 1 = data
- lcd_rw  out  1  tied 0 (write only)
- sf_ce0  out  1  tied 1 (StrataFlash disabled, shared data bus)
- init_done  out  1  high from the end of the init sequence until reset
- frame_done  out  1  one-cycle pulse after the final wait of each full frame

Behaviour:
- Reset (async, any state): lcd_d=0, lcd_e=0, lcd_rs=0, init_done=0, frame_done=0; FSM → POWERON; all counters cleared. Reset mid-transfer aborts immediately and the full init reruns. No partial-frame resume.

Nibble primitive (NIB):
- SETUP: lcd_d and lcd_rs driven, E=0, T_SU cycles.
- PULSE: E=1, T_E cycles.
- HOLD: E=0, data held, T_H cycles.
- Data and RS never change while E=1.

Byte primitive:
- NIB(upper nibble), wait T_NIB, NIB(lower nibble), wait T_CMD.
- Cycle cost per byte = 2*(T_SU+T_E+T_H)+T_NIB+T_CMD.

FSM states: POWERON → INIT1..INIT4 → CFG_FUNC → CFG_ENTRY → CFG_DISP → CFG_CLR → ADDR1 → ROW1 → ADDR2 → ROW2 → back to ADDR1.
- POWERON: wait T_POWERON cycles.
- INIT1..INIT4: single nibbles, rs=0.
  - INIT1: 0x3, then wait T_INIT_LONG.
  - INIT2: 0x3, then wait T_INIT_SHORT.
  - INIT3: 0x3, then wait T_CMD.
  - INIT4: 0x2, then wait T_CMD.
- Config bytes, all rs=0:
  - CFG_FUNC: 0x28.
  - CFG_ENTRY: 0x06.
  - CFG_DISP: 0x0C.
  - CFG_CLR: 0x01, then an additional T_CLEAR wait.
- init_done rises on the cycle CFG_CLR's wait completes, and stays high.
- Frame, repeated forever:
  - ADDR1: command 0x80.
  - ROW1: 16 data bytes (rs=1), column 0 first.
  - ADDR2: command 0xC0.
  - ROW2: 16 data bytes (rs=1), column 0 first.
  - frame_done pulses for one cycle when the last ROW2 byte's T_CMD wait ends; the next cycle starts ADDR1.
- Snapshot: line1 and line2 are captured together into internal 256-bit shadow registers on entry to ADDR1. Changes to the inputs during a frame appear only in the next frame (no tearing).
- Bytes are passed unmodified; no ASCII validation.
- Column index is 4 bits and wraps 15→0 with the row switch. Row index selects the shadow half.
- Counters are sized for the largest parameter and have no overflow path. A wait of N means exactly N cycles.
- lcd_rw=0 and sf_ce0=1 at all times, including during reset.

Test Plan (bench overrides delays: T_POWERON=20, T_INIT_LONG=10, T_INIT_SHORT=6, T_CMD=4, T_CLEAR=8, T_SU=2, T_E=3, T_H=1, T_NIB=2):
- Reset release → 20 cycles idle, then E-pulse nibble sequence 3,3,3,2 (rs=0), then bytes 28,06,0C,01. Exactly 12 E pulses before init_done=1.
- Spacing check: each E pulse high exactly 3 cycles. lcd_d/lcd_rs stable from 2 cycles before E rises to 1 cycle after E falls. Byte period = 2*(6)+2+4 = 18 cycles.
- line1=ASCII "0000000000000001", line2=all 0x30 → first frame: 80, then 16 rs=1 bytes ending 0x31, C0, 16×0x30. 68 E pulses per frame; frame_done one-cycle pulse; second frame identical.
- line1 changed to all 0x41 mid-ROW1 → rest of current frame unchanged; next frame ROW1 = 16×0x41.
- Assert reset during ROW2 at an E-high cycle → lcd_e=0 asynchronously, init_done=0. After release, a full init sequence (12 pulses) precedes any data.
- Throughout all tests lcd_rw=0, sf_ce0=1. No E pulse occurs with rs=1 before init_done.

Source files
------------

// File: rtl/lcd_char_driver_if.sv
// LCD pin bundle for the HD44780-style character display.
// Master drives the pins; slave observes them (board top or a bench).
//   lcd_d  : data nibble DB7..DB4
//   lcd_e  : enable strobe
//   lcd_rs : 0 = command, 1 = data
//   lcd_rw : write-only, held 0
//   sf_ce0 : StrataFlash chip enable, held 1 (shared data bus)
interface lcd_char_driver_if;
    logic [3:0] lcd_d;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       sf_ce0;

    modport master (
        output lcd_d,
        output lcd_e,
        output lcd_rs,
        output lcd_rw,
        output sf_ce0
    );

    modport slave (
        input lcd_d,
        input lcd_e,
        input lcd_rs,
        input lcd_rw,
        input sf_ce0
    );
endinterface

// File: rtl/lcd_char_driver.sv
// Character LCD driver: 4-bit HD44780 init, then endless refresh of
// two 16-char rows from snapshots of line1/line2.
// Ports:
//   clk, reset      : clock, async active-high reset
//   line1, line2    : row ASCII, [127:120] = column 0
//   lcd             : LCD pin bundle (master)
//   init_done       : high once init has finished, until reset
//   frame_done      : one-cycle pulse at the end of each frame
module lcd_char_driver #(
    parameter int unsigned T_POWERON    = 750000,
    parameter int unsigned T_INIT_LONG  = 205000,
    parameter int unsigned T_INIT_SHORT = 5000,
    parameter int unsigned T_CMD        = 2000,
    parameter int unsigned T_CLEAR      = 82000,
    parameter int unsigned T_SU         = 2,
    parameter int unsigned T_E          = 12,
    parameter int unsigned T_H          = 1,
    parameter int unsigned T_NIB        = 50
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [127:0]             line1,
    input  logic [127:0]             line2,
    lcd_char_driver_if.master        lcd,
    output logic                     init_done,
    output logic                     frame_done
);

    function automatic int unsigned max2(
        input int unsigned a,
        input int unsigned b
    );
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned T_CLR_WAIT = T_CMD + T_CLEAR;
    localparam int unsigned T_MAX =
        max2(max2(max2(T_POWERON, T_INIT_LONG),
                  max2(T_INIT_SHORT, T_CLR_WAIT)),
             max2(max2(T_SU, T_E), max2(T_H, T_NIB)));
    localparam int CW = $clog2(T_MAX + 1);

    typedef enum logic [3:0] {
        S_POWERON,
        S_INIT1,
        S_INIT2,
        S_INIT3,
        S_INIT4,
        S_FUNC,
        S_ENTRY,
        S_DISP,
        S_CLR,
        S_ADDR1,
        S_ROW1,
        S_ADDR2,
        S_ROW2
    } state_t;

    // Sub-sequence inside each step: nibble strobe, inter-nibble gap,
    // and the post-step settle wait.
    typedef enum logic [2:0] {
        P_SETUP,
        P_PULSE,
        P_HOLD,
        P_GAP,
        P_WAIT
    } phase_t;

    state_t         state, state_n;
    phase_t         phase, phase_n;
    logic [CW-1:0]  cnt, cnt_n, lim;
    logic           done;
    logic           hi, hi_n;
    logic [3:0]     col, col_n;
    logic [127:0]   sh1, sh2;
    logic           snap;
    logic           single;
    logic [3:0]     d_q, d_n;
    logic           rs_q, rs_n;
    logic           e_q;
    logic           init_q, init_n;
    logic           fd_q, fd_n;
    logic [7:0]     byte_n;
    logic           byte_rs;
    logic           load;

    assign single = (state == S_INIT1) || (state == S_INIT2) ||
                    (state == S_INIT3) || (state == S_INIT4);

    // Length of the current phase in cycles.
    always_comb begin
        lim = CW'(T_CMD);
        unique case (phase)
            P_SETUP: lim = CW'(T_SU);
            P_PULSE: lim = CW'(T_E);
            P_HOLD:  lim = CW'(T_H);
            P_GAP:   lim = CW'(T_NIB);
            default: begin
                unique case (state)
                    S_POWERON: lim = CW'(T_POWERON);
                    S_INIT1:   lim = CW'(T_INIT_LONG);
                    S_INIT2:   lim = CW'(T_INIT_SHORT);
                    S_CLR:     lim = CW'(T_CLR_WAIT);
                    default:   lim = CW'(T_CMD);
                endcase
            end
        endcase
    end

    assign done = (cnt == lim - 1'b1);

    always_comb begin
        state_n = state;
        phase_n = phase;
        cnt_n   = cnt + 1'b1;
        hi_n    = hi;
        col_n   = col;
        init_n  = init_q;
        fd_n    = 1'b0;
        snap    = 1'b0;
        if (done) begin
            cnt_n = '0;
            unique case (phase)
                P_SETUP: phase_n = P_PULSE;
                P_PULSE: phase_n = P_HOLD;
                P_HOLD: begin
                    if (single || !hi) begin
                        phase_n = P_WAIT;
                    end else begin
                        phase_n = P_GAP;
                        hi_n    = 1'b0;
                    end
                end
                P_GAP: phase_n = P_SETUP;
                default: begin
                    phase_n = P_SETUP;
                    hi_n    = 1'b1;
                    unique case (state)
                        S_POWERON: state_n = S_INIT1;
                        S_INIT1:   state_n = S_INIT2;
                        S_INIT2:   state_n = S_INIT3;
                        S_INIT3:   state_n = S_INIT4;
                        S_INIT4:   state_n = S_FUNC;
                        S_FUNC:    state_n = S_ENTRY;
                        S_ENTRY:   state_n = S_DISP;
                        S_DISP:    state_n = S_CLR;
                        S_CLR: begin
                            state_n = S_ADDR1;
                            init_n  = 1'b1;
                            snap    = 1'b1;
                        end
                        S_ADDR1: begin
                            state_n = S_ROW1;
                            col_n   = 4'd0;
                        end
                        S_ROW1: begin
                            col_n = col + 1'b1;
                            if (col == 4'hf)
                                state_n = S_ADDR2;
                        end
                        S_ADDR2: begin
                            state_n = S_ROW2;
                            col_n   = 4'd0;
                        end
                        S_ROW2: begin
                            col_n = col + 1'b1;
                            if (col == 4'hf) begin
                                state_n = S_ADDR1;
                                fd_n    = 1'b1;
                                snap    = 1'b1;
                            end
                        end
                        default: state_n = S_POWERON;
                    endcase
                end
            endcase
        end
    end

    // Byte for the step being entered. Init nibbles are encoded as
    // 0x33/0x22 so either nibble select yields the right value.
    always_comb begin
        byte_n  = 8'h00;
        byte_rs = 1'b0;
        unique case (state_n)
            S_INIT1, S_INIT2, S_INIT3: byte_n = 8'h33;
            S_INIT4:  byte_n = 8'h22;
            S_FUNC:   byte_n = 8'h28;
            S_ENTRY:  byte_n = 8'h06;
            S_DISP:   byte_n = 8'h0C;
            S_CLR:    byte_n = 8'h01;
            S_ADDR1:  byte_n = 8'h80;
            S_ADDR2:  byte_n = 8'hC0;
            S_ROW1: begin
                byte_n  = sh1[{~col_n, 3'b000} +: 8];
                byte_rs = 1'b1;
            end
            S_ROW2: begin
                byte_n  = sh2[{~col_n, 3'b000} +: 8];
                byte_rs = 1'b1;
            end
            default: byte_n = 8'h00;
        endcase
    end

    // Data/RS only change on entry to SETUP, so they are frozen
    // through PULSE and HOLD.
    assign load = (phase_n == P_SETUP) && (phase != P_SETUP);

    always_comb begin
        d_n  = d_q;
        rs_n = rs_q;
        if (load) begin
            d_n  = hi_n ? byte_n[7:4] : byte_n[3:0];
            rs_n = byte_rs;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_POWERON;
            phase  <= P_WAIT;
            cnt    <= '0;
            hi     <= 1'b1;
            col    <= 4'd0;
            sh1    <= '0;
            sh2    <= '0;
            d_q    <= 4'd0;
            rs_q   <= 1'b0;
            e_q    <= 1'b0;
            init_q <= 1'b0;
            fd_q   <= 1'b0;
        end else begin
            state  <= state_n;
            phase  <= phase_n;
            cnt    <= cnt_n;
            hi     <= hi_n;
            col    <= col_n;
            d_q    <= d_n;
            rs_q   <= rs_n;
            e_q    <= (phase_n == P_PULSE);
            init_q <= init_n;
            fd_q   <= fd_n;
            if (snap) begin
                sh1 <= line1;
                sh2 <= line2;
            end
        end
    end

    assign lcd.lcd_d  = d_q;
    assign lcd.lcd_e  = e_q;
    assign lcd.lcd_rs = rs_q;
    assign lcd.lcd_rw = 1'b0;
    assign lcd.sf_ce0 = 1'b1;
    assign init_done  = init_q;
    assign frame_done = fd_q;

endmodule
